// File: rtl/ysyx_22040895_dmem_bridge_pkg.sv
// Shared types and constants for the data-memory AXI4-Lite bridge.
package ysyx_22040895_dmem_bridge_pkg;

  localparam int unsigned DATA_W_DEF = 64;
  localparam int unsigned ADDR_W_DEF = 64;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    MU_BYTE  = 2'b00,
    MU_HALF  = 2'b01,
    MU_WORD  = 2'b10,
    MU_DWORD = 2'b11
  } munit_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_A  = 3'd1,
    S_RD_D  = 3'd2,
    S_WR_AW = 3'd3,
    S_WR_B  = 3'd4,
    S_DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/ysyx_22040895_lane_align.sv
// Byte-lane steering for the 64-bit bus: store strobe/data shift, load extract, alignment check.
module ysyx_22040895_lane_align
  import ysyx_22040895_dmem_bridge_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic [1:0]                   unit_i,
  input  logic [$clog2(DATA_W/8)-1:0]  off_i,
  input  logic [DATA_W-1:0]            wdata_i,
  input  logic [DATA_W-1:0]            rdata_i,
  output logic [DATA_W/8-1:0]          wstrb_o,
  output logic [DATA_W-1:0]            wdata_o,
  output logic [DATA_W-1:0]            rdata_o,
  output logic                         misalign_o
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);

  logic [STRB_W-1:0] strb_base;
  logic [OFF_W-1:0]  align_mask;
  logic [DATA_W-1:0] size_mask;

  always_comb begin
    strb_base  = '0;
    align_mask = '0;
    unique case (munit_e'(unit_i))
      MU_BYTE:  begin strb_base = STRB_W'(8'h01); align_mask = OFF_W'(0); end
      MU_HALF:  begin strb_base = STRB_W'(8'h03); align_mask = OFF_W'(1); end
      MU_WORD:  begin strb_base = STRB_W'(8'h0F); align_mask = OFF_W'(3); end
      MU_DWORD: begin strb_base = '1;             align_mask = OFF_W'(7); end
      default:  begin strb_base = '0;             align_mask = '0;        end
    endcase
  end

  // Byte-enable pattern expanded to a bit mask for the load extract.
  always_comb begin
    size_mask = '0;
    for (int unsigned i = 0; i < STRB_W; i++) begin
      size_mask[8*i +: 8] = {8{strb_base[i]}};
    end
  end

  assign misalign_o = |(off_i & align_mask);
  assign wstrb_o    = strb_base << off_i;
  assign wdata_o    = wdata_i << {off_i, 3'b000};
  assign rdata_o    = (rdata_i >> {off_i, 3'b000}) & size_mask;

endmodule

// File: rtl/ysyx_22040895_dmem_bridge.sv
// Memory-stage load/store responder: one request becomes one AXI4-Lite transaction.
module ysyx_22040895_dmem_bridge
  import ysyx_22040895_dmem_bridge_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mce_i,
  input  logic                mwe_i,
  input  logic [1:0]          munit_i,
  input  logic [ADDR_W-1:0]   maddr_i,
  input  logic [DATA_W-1:0]   wmdata_i,
  output logic [DATA_W-1:0]   rmdata_o,
  output logic                stall_o,
  output logic                err_o,
  output logic                awvalid_o,
  input  logic                awready_i,
  output logic [ADDR_W-1:0]   awaddr_o,
  output logic                wvalid_o,
  input  logic                wready_i,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  input  logic                bvalid_i,
  output logic                bready_o,
  input  logic [1:0]          bresp_i,
  output logic                arvalid_o,
  input  logic                arready_i,
  output logic [ADDR_W-1:0]   araddr_o,
  input  logic                rvalid_i,
  output logic                rready_o,
  input  logic [DATA_W-1:0]   rdata_i,
  input  logic [1:0]          rresp_i
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);

  state_e              state_q,    state_d;
  logic                we_q,       we_d;
  munit_e              unit_q,     unit_d;
  logic [ADDR_W-1:0]   addr_q,     addr_d;
  logic [DATA_W-1:0]   wdata_q,    wdata_d;
  logic [STRB_W-1:0]   wstrb_q,    wstrb_d;
  logic                misal_q,    misal_d;
  logic [1:0]          resp_q,     resp_d;
  logic [DATA_W-1:0]   rdata_q,    rdata_d;
  logic                aw_done_q,  aw_done_d;
  logic                w_done_q,   w_done_d;

  logic                idle;
  logic [1:0]          al_unit;
  logic [OFF_W-1:0]    al_off;
  logic [STRB_W-1:0]   al_wstrb;
  logic [DATA_W-1:0]   al_wdata;
  logic [DATA_W-1:0]   al_rdata;
  logic                al_misal;
  logic                done_err;

  assign idle = (state_q == S_IDLE);

  // One aligner serves both paths: live request in IDLE, latched request afterwards.
  assign al_unit = idle ? munit_i : unit_q;
  assign al_off  = idle ? maddr_i[OFF_W-1:0] : addr_q[OFF_W-1:0];

  ysyx_22040895_lane_align #(
    .DATA_W (DATA_W)
  ) u_lane_align (
    .unit_i     (al_unit),
    .off_i      (al_off),
    .wdata_i    (wmdata_i),
    .rdata_i    (rdata_q),
    .wstrb_o    (al_wstrb),
    .wdata_o    (al_wdata),
    .rdata_o    (al_rdata),
    .misalign_o (al_misal)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      we_q      <= 1'b0;
      unit_q    <= MU_BYTE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      misal_q   <= 1'b0;
      resp_q    <= RESP_OKAY;
      rdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      unit_q    <= unit_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      misal_q   <= misal_d;
      resp_q    <= resp_d;
      rdata_q   <= rdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    unit_d    = unit_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    misal_d   = misal_q;
    resp_d    = resp_q;
    rdata_d   = rdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;

    unique case (state_q)
      S_IDLE: begin
        if (mce_i) begin
          we_d      = mwe_i;
          unit_d    = munit_e'(munit_i);
          addr_d    = maddr_i;
          wdata_d   = al_wdata;
          wstrb_d   = al_wstrb;
          misal_d   = al_misal;
          resp_d    = RESP_OKAY;
          rdata_d   = '0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (al_misal)   state_d = S_DONE;
          else if (mwe_i) state_d = S_WR_AW;
          else            state_d = S_RD_A;
        end
      end
      S_RD_A: begin
        if (arready_i) state_d = S_RD_D;
      end
      S_RD_D: begin
        if (rvalid_i) begin
          rdata_d = rdata_i;
          resp_d  = rresp_i;
          state_d = S_DONE;
        end
      end
      S_WR_AW: begin
        // Sticky per-channel flags so an accepted AW or W is never re-presented.
        aw_done_d = aw_done_q | awready_i;
        w_done_d  = w_done_q  | wready_i;
        if (aw_done_d && w_done_d) state_d = S_WR_B;
      end
      S_WR_B: begin
        if (bvalid_i) begin
          resp_d  = bresp_i;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign done_err  = misal_q || (resp_q != RESP_OKAY);
  assign err_o     = (state_q == S_DONE) && done_err;
  assign rmdata_o  = ((state_q == S_DONE) && !we_q && !done_err) ? al_rdata : '0;

  assign stall_o   = (idle && mce_i) ||
                     (state_q == S_RD_A) || (state_q == S_RD_D) ||
                     (state_q == S_WR_AW) || (state_q == S_WR_B);

  assign arvalid_o = (state_q == S_RD_A);
  assign araddr_o  = addr_q;
  assign rready_o  = (state_q == S_RD_D);
  assign awvalid_o = (state_q == S_WR_AW) && !aw_done_q;
  assign awaddr_o  = addr_q;
  assign wvalid_o  = (state_q == S_WR_AW) && !w_done_q;
  assign wdata_o   = wdata_q;
  assign wstrb_o   = wstrb_q;
  assign bready_o  = (state_q == S_WR_B);

endmodule

// File: tb/tb_ysyx_22040895_dmem_bridge.sv
// Randomized bench for the dmem bridge with a latency-programmable AXI4-Lite slave.
module tb_ysyx_22040895_dmem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        mce, mwe;
  logic [1:0]  munit;
  logic [63:0] maddr, wmdata, rmdata;
  logic        stall, err;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [63:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  wstrb;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  ysyx_22040895_dmem_bridge #(
    .DATA_W (64),
    .ADDR_W (64)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mce_i     (mce),
    .mwe_i     (mwe),
    .munit_i   (munit),
    .maddr_i   (maddr),
    .wmdata_i  (wmdata),
    .rmdata_o  (rmdata),
    .stall_o   (stall),
    .err_o     (err),
    .awvalid_o (awvalid),
    .awready_i (awready),
    .awaddr_o  (awaddr),
    .wvalid_o  (wvalid),
    .wready_i  (wready),
    .wdata_o   (wdata),
    .wstrb_o   (wstrb),
    .bvalid_i  (bvalid),
    .bready_o  (bready),
    .bresp_i   (bresp),
    .arvalid_o (arvalid),
    .arready_i (arready),
    .araddr_o  (araddr),
    .rvalid_i  (rvalid),
    .rready_o  (rready),
    .rdata_i   (rdata),
    .rresp_i   (rresp)
  );

  // Slave knobs: each channel answers after the given number of waiting cycles.
  int unsigned s_ar_wait, s_r_wait, s_aw_wait, s_w_wait, s_b_wait;
  logic [63:0] s_rdata;
  logic [1:0]  s_rresp, s_bresp;

  int unsigned ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
  int unsigned ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic [63:0] seen_araddr, seen_awaddr, seen_wdata;
  logic [7:0]  seen_wstrb;

  always_comb begin
    arready = arvalid && (ar_cnt >= s_ar_wait);
    rvalid  = rready  && (r_cnt  >= s_r_wait);
    awready = awvalid && (aw_cnt >= s_aw_wait);
    wready  = wvalid  && (w_cnt  >= s_w_wait);
    bvalid  = bready  && (b_cnt  >= s_b_wait);
    rdata   = rvalid ? s_rdata : 64'd0;
    rresp   = s_rresp;
    bresp   = s_bresp;
  end

  always @(posedge clk) begin
    if (!rst) begin
      ar_cnt <= 0; r_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
    end else begin
      ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
      r_cnt  <= (rready  && !rvalid)  ? r_cnt  + 1 : 0;
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid  && !wready)  ? w_cnt  + 1 : 0;
      b_cnt  <= (bready  && !bvalid)  ? b_cnt  + 1 : 0;
      if (arvalid && arready) begin ar_hs <= ar_hs + 1; seen_araddr <= araddr; end
      if (rvalid && rready)   r_hs <= r_hs + 1;
      if (awvalid && awready) begin aw_hs <= aw_hs + 1; seen_awaddr <= awaddr; end
      if (wvalid && wready) begin
        w_hs <= w_hs + 1; seen_wdata <= wdata; seen_wstrb <= wstrb;
      end
      if (bvalid && bready)   b_hs <= b_hs + 1;
    end
  end

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: expected result and completion cycle from size/offset arithmetic and slave waits.
  task automatic run_txn(input logic we, input logic [1:0] unit, input logic [63:0] addr,
                         input logic [63:0] wd, input logic [63:0] rd, input logic [1:0] rsp,
                         input int unsigned ar_w, input int unsigned r_w,
                         input int unsigned aw_w, input int unsigned w_w,
                         input int unsigned b_w);
    int unsigned sz, off, d, ar0, r0, aw0, w0, b0;
    logic        misal, e, is_rd, is_wr;
    logic [63:0] mask, exp_rd, exp_wd;
    logic [7:0]  exp_strb;
    sz       = 1 << unit;
    off      = int'(addr % 8);
    misal    = (addr % sz) != 0;
    mask     = (sz == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * sz)) - 64'd1);
    exp_wd   = wd << (8 * off);
    exp_strb = 8'((1 << sz) - 1) << off;
    exp_rd   = (rd >> (8 * off)) & mask;
    e        = misal || (rsp != 2'b00);
    is_rd    = !we && !misal;
    is_wr    = we && !misal;
    if (misal)   d = 1;
    else if (we) d = 3 + ((aw_w > w_w) ? aw_w : w_w) + b_w;
    else         d = 3 + ar_w + r_w;
    if (we || e) exp_rd = 64'd0;

    s_ar_wait = ar_w; s_r_wait = r_w; s_aw_wait = aw_w; s_w_wait = w_w; s_b_wait = b_w;
    s_rdata = rd; s_rresp = rsp; s_bresp = rsp;
    ar0 = ar_hs; r0 = r_hs; aw0 = aw_hs; w0 = w_hs; b0 = b_hs;

    for (int unsigned c = 0; c <= d + 1; c++) begin
      @(negedge clk);
      if (c == 0) begin
        mwe = we; munit = unit; maddr = addr; wmdata = wd;
      end
      mce = (c < d);
      #1;
      check("stall", {63'd0, stall}, {63'd0, c < d});
      check("err", {63'd0, err}, {63'd0, (c == d) && e});
      check("rmdata", rmdata, (c == d) ? exp_rd : 64'd0);
    end

    check("ar_hs", 64'(ar_hs - ar0), {63'd0, is_rd});
    check("r_hs",  64'(r_hs - r0),   {63'd0, is_rd});
    check("aw_hs", 64'(aw_hs - aw0), {63'd0, is_wr});
    check("w_hs",  64'(w_hs - w0),   {63'd0, is_wr});
    check("b_hs",  64'(b_hs - b0),   {63'd0, is_wr});
    if (is_rd) check("araddr", seen_araddr, addr);
    if (is_wr) begin
      check("awaddr", seen_awaddr, addr);
      check("wstrb", {56'd0, seen_wstrb}, {56'd0, exp_strb});
      check("wdata", seen_wdata, exp_wd);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        r_we;
    logic [1:0]  r_unit, r_rsp;
    logic [63:0] r_addr, r_wd, r_rd;

    rst = 1'b0; mce = 1'b0; mwe = 1'b0; munit = 2'b00; maddr = '0; wmdata = '0;
    s_ar_wait = 0; s_r_wait = 0; s_aw_wait = 0; s_w_wait = 0; s_b_wait = 0;
    s_rdata = '0; s_rresp = 2'b00; s_bresp = 2'b00;
    ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
    seen_araddr = '0; seen_awaddr = '0; seen_wdata = '0; seen_wstrb = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1; #1;
    check("rst_stall", {63'd0, stall}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    check("rst_rmdata", rmdata, 64'd0);
    check("rst_valids", {59'd0, arvalid, rready, awvalid, wvalid, bready}, 64'd0);

    run_txn(1'b0, 2'b11, 64'h8000_0000, 64'd0, 64'h1122_3344_5566_7788, 2'b00, 0, 0, 0, 0, 0);
    run_txn(1'b0, 2'b00, 64'h8000_0005, 64'd0, 64'h1122_3344_5566_7788, 2'b00, 0, 0, 0, 0, 0);
    run_txn(1'b0, 2'b01, 64'h8000_0006, 64'd0, 64'h1122_3344_5566_7788, 2'b00, 0, 0, 0, 0, 0);
    run_txn(1'b1, 2'b10, 64'h8000_0004, 64'hDEAD_BEEF, 64'd0, 2'b00, 0, 0, 2, 0, 1);
    run_txn(1'b1, 2'b01, 64'h8000_0003, 64'h1234, 64'd0, 2'b00, 0, 0, 0, 0, 0);
    run_txn(1'b0, 2'b11, 64'h8000_0010, 64'd0, 64'hCAFE_F00D_0BAD_BEEF, 2'b10, 3, 0, 0, 0, 0);
    run_txn(1'b1, 2'b11, 64'h8000_0018, 64'h0102_0304_0506_0708, 64'd0, 2'b11, 0, 0, 0, 3, 2);

    // Reset asserted while the read data phase is pending abandons the transaction.
    s_ar_wait = 0; s_r_wait = 20; s_rresp = 2'b00;
    @(negedge clk); mce = 1'b1; mwe = 1'b0; munit = 2'b11; maddr = 64'h8000_0020; #1;
    check("mid_stall0", {63'd0, stall}, 64'd1);
    @(negedge clk); #1;
    check("mid_arvalid", {63'd0, arvalid}, 64'd1);
    @(negedge clk); #1;
    check("mid_rready", {63'd0, rready}, 64'd1);
    rst = 1'b0;
    @(negedge clk); rst = 1'b1; mce = 1'b0; #1;
    check("mid_arvalid_rst", {63'd0, arvalid}, 64'd0);
    check("mid_rready_rst", {63'd0, rready}, 64'd0);
    check("mid_stall_idle", {63'd0, stall}, 64'd0);
    mce = 1'b1; #1;
    check("mid_stall_req", {63'd0, stall}, 64'd1);
    mce = 1'b0;

    for (int i = 0; i < 150; i++) begin
      r_we   = 1'($urandom_range(0, 1));
      r_unit = 2'($urandom_range(0, 3));
      r_addr = {32'h0, 32'h8000_0000 + ($urandom_range(0, 255) << 3)} | 64'($urandom_range(0, 7));
      r_wd   = {$urandom, $urandom};
      r_rd   = {$urandom, $urandom};
      r_rsp  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      run_txn(r_we, r_unit, r_addr, r_wd, r_rd, r_rsp,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22040895_dmem_bridge.md
# ysyx_22040895_dmem_bridge

Data-memory responder at the far end of the core's memory-stage request interface: accepts one load/store request (chip enable, write enable, access unit, address, store data), converts it into a single AXI4-Lite transaction on a 64-bit bus and returns lane-extracted load data. It holds the pipeline via a stall output until the transaction completes, so the memory stage sees a fixed request/response contract regardless of bus latency.

## Interface
- DATA_W, 64: bus and register width (RegBus).
- ADDR_W, 64: address width.
- clk  in  1  core clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- mce_i  in  1  request valid (load or store).
- mwe_i  in  1  1 = store, 0 = load; sampled with mce_i.
- munit_i  in  2  access size: 00 byte, 01 half, 10 word, 11 dword.
- maddr_i  in  ADDR_W  byte address.
- wmdata_i  in  DATA_W  store data, right-aligned.
- rmdata_o  out  DATA_W  load data, right-aligned, zero-extended; valid only in DONE.
- stall_o  out  1  holds memory stage while request is in flight.
- err_o  out  1  one-cycle pulse in DONE on misalignment or non-OKAY response.
- AXI4-Lite master: awvalid/awready/awaddr, wvalid/wready/wdata/wstrb(8), bvalid/bready/bresp(2), arvalid/arready/araddr, rvalid/rready/rdata/rresp(2).

## Operation
- States: IDLE, RD_A, RD_D, WR_AW, WR_B, DONE.
- IDLE: mce_i=1 latches mwe, munit, addr, shifted wdata, wstrb; misaligned -> DONE with err; load -> RD_A; store -> WR_AW.
- Misaligned: half with addr[0]!=0, word with addr[1:0]!=0, dword with addr[2:0]!=0. No bus transaction issued.
- Lane rules (off = addr[2:0]): mask = 0x01/0x03/0x0F/0xFF by munit; wstrb = mask<<off; wdata = wmdata_i<<(8*off); rmdata_o = (rdata>>(8*off)) AND size mask.
- araddr/awaddr = latched address unmodified.
- RD_A: arvalid=1 until arready; then RD_D. RD_D: rready=1; on rvalid capture rdata, rresp -> DONE.
- WR_AW: awvalid and wvalid asserted together; each drops independently after its own handshake (per-channel done flags); both done -> WR_B. WR_B: bready=1; on bvalid capture bresp -> DONE.
- DONE: one cycle; rmdata_o valid (zero for stores/errors); err_o=1 if misaligned or resp!=00. Next state IDLE unconditionally.
- stall_o = (IDLE and mce_i) or state in {RD_A, RD_D, WR_AW, WR_B}; 0 in DONE.
- Inputs ignored outside IDLE; memory stage must hold them stable while stall_o=1.

## Timing
- Reset (rst=0 at edge): state IDLE; all valid/ready outputs 0; rmdata_o 0; err_o 0; flags cleared. Reset mid-transaction abandons it; slave shares the reset.
- Load, zero-wait slave: request at cycle 0, arvalid cycle 1, rready cycle 2, DONE cycle 3; stall_o high cycles 0-2.
- Store, zero-wait slave: aw/w valid cycle 1, bready cycle 2, DONE cycle 3.
- Misaligned: DONE at cycle 1, stall_o high cycle 0 only.
- Each additional slave wait cycle adds exactly one cycle to stall.
- awready before wready (or reverse) in different cycles: no re-issue of the accepted channel.
- Back-to-back requests: minimum one IDLE cycle between DONE and next latch.

## Structure
- Shared package: munit encodings, FSM state encoding, RESP_OKAY, DATA_W/ADDR_W defaults.
- Sub-module ysyx_22040895_lane_align: combinational wstrb/wdata shift, rdata extract, misalign detect.

## Test plan
- Load dword addr 0x8000_0000, rdata 0x1122334455667788, zero-wait -> rmdata_o 0x1122334455667788 in cycle 3, stall_o 1 for cycles 0-2, err_o 0.
- Load byte addr 0x8000_0005, same rdata -> rmdata_o 0x33; load half addr 0x...6 -> 0x1122.
- Store word 0xDEADBEEF to addr 0x...4 -> wstrb 0xF0, wdata 0xDEADBEEF_00000000; awready 2 cycles after wready -> single W handshake, DONE after bvalid.
- Store half to addr 0x...3 -> no aw/w/ar valid ever, err_o pulse cycle 1, stall_o 1 only cycle 0.
- Read with rresp=2'b10 and arready delayed 3 cycles -> err_o 1 in DONE, DONE at cycle 6.
- rst=0 asserted while in RD_D -> next cycle IDLE, arvalid/rready 0, stall_o follows mce_i.
